// File: rtl/keycode_event_queue.sv
// Turns successive PIO keycode words into press/release events queued in a FWFT FIFO.
// Optional typematic repeat events are compiled in with `define KEYCODE_REPEAT_EN.

// Generic first-word-fall-through FIFO; head entry is always visible on pop_dat.
// Latency: a push is visible on pop_vld the cycle after it is accepted.
// Backpressure: push_rdy drops only when full and no pop happens in the same cycle.
module keycode_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  output logic                       push_rdy,
  output logic                       pop_vld,
  input  logic                       pop_rdy,
  output logic [WIDTH-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign pop_vld  = (count != '0);
  assign pop_dat  = mem[rd_ptr];
  assign do_pop   = pop_vld && pop_rdy;
  assign push_rdy = (count != FULL) || do_pop;
  assign do_push  = push_vld && push_rdy;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// Diffs normalised keycode words and serialises release/press (and repeat) events.
// Latency: keycode change at cycle 0 gives first event on evt_valid at cycle 3.
// Backpressure: events arriving while the FIFO is full are dropped and flagged in overflow.
module keycode_event_queue #(
  parameter int FIFO_DEPTH   = 8,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   keycode,
  input  logic                          frame_tick,
  output logic [9:0]                    evt_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);
  typedef enum logic [2:0] {IDLE, REL0, REL1, PRS0, PRS1} state_t;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_repeat
    $error("REPEAT_RATE must be in 1..REPEAT_DELAY");
  end

  // A slot1 code duplicating a live slot0 code is the same key reported twice.
  function automatic logic [15:0] norm_kc(input logic [15:0] w);
    return (w[15:8] == w[7:0] && w[7:0] != 8'h00) ? {8'h00, w[7:0]} : w;
  endfunction

  function automatic logic absent(input logic [7:0] code, input logic [15:0] w);
    return (code != 8'h00) && (code != w[7:0]) && (code != w[15:8]);
  endfunction

  state_t      state, state_nxt;
  logic [15:0] kc_q, kc_n, prev, snap;
  logic        push_vld, push_rdy;
  logic [9:0]  push_dat, head_dat;

  assign kc_n = norm_kc(kc_q);

  // snap and prev only ever hold normalised words.
  always_ff @(posedge clk) begin
    if (reset) begin
      kc_q  <= 16'h0000;
      prev  <= 16'h0000;
      snap  <= 16'h0000;
      state <= IDLE;
    end else begin
      kc_q  <= keycode;
      state <= state_nxt;
      if (state == IDLE && state_nxt == REL0) snap <= kc_n;
      if (state == PRS1) prev <= snap;
    end
  end

`ifdef KEYCODE_REPEAT_EN
  localparam int CW = $clog2(REPEAT_DELAY + 1);
  logic [CW-1:0] rpt_cnt;
  logic          rpt_pending, rpt_take;

  // Any change to the held slot0 key restarts the typematic timebase.
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt     <= '0;
      rpt_pending <= 1'b0;
    end else if (state == PRS1 && snap[7:0] != prev[7:0]) begin
      rpt_cnt     <= '0;
      rpt_pending <= 1'b0;
    end else begin
      if (rpt_take) rpt_pending <= 1'b0;
      if (frame_tick && prev[7:0] != 8'h00) begin
        if (rpt_cnt == CW'(REPEAT_DELAY - 1)) begin
          rpt_cnt     <= CW'(REPEAT_DELAY - REPEAT_RATE);
          rpt_pending <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + 1'b1;
        end
      end
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    push_vld  = 1'b0;
    push_dat  = 10'h000;
`ifdef KEYCODE_REPEAT_EN
    rpt_take  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (kc_n != prev) begin
          state_nxt = REL0;
`ifdef KEYCODE_REPEAT_EN
        end else if (rpt_pending) begin
          push_vld = 1'b1;
          push_dat = {2'b11, prev[7:0]};
          rpt_take = 1'b1;
`endif
        end
      end
      REL0: begin
        state_nxt = REL1;
        push_vld  = absent(prev[7:0], snap);
        push_dat  = {2'b00, prev[7:0]};
      end
      REL1: begin
        state_nxt = PRS0;
        push_vld  = absent(prev[15:8], snap);
        push_dat  = {2'b00, prev[15:8]};
      end
      PRS0: begin
        state_nxt = PRS1;
        push_vld  = absent(snap[7:0], prev);
        push_dat  = {2'b01, snap[7:0]};
      end
      PRS1: begin
        state_nxt = IDLE;
        push_vld  = absent(snap[15:8], prev);
        push_dat  = {2'b01, snap[15:8]};
      end
      default: state_nxt = IDLE;
    endcase
  end

  keycode_event_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .push_rdy (push_rdy),
    .pop_vld  (evt_valid),
    .pop_rdy  (evt_ready),
    .pop_dat  (head_dat),
    .count    (fifo_count)
  );

`ifdef KEYCODE_REPEAT_EN
  assign evt_data = head_dat;
`else
  assign evt_data = head_dat & 10'h1FF;
`endif

  always_ff @(posedge clk) begin
    if (reset)                        overflow <= 1'b0;
    else if (push_vld && !push_rdy)   overflow <= 1'b1;
    else if (ovf_clr)                 overflow <= 1'b0;
  end
endmodule

// File: doc/keycode_event_queue.md
Name: keycode_event_queue

Overview:
- Sits directly downstream of the keycode0 PIO output port.
- Consumes the 16-bit keycode word the NIOS writes: two 8-bit USB HID usage codes, slot0 = [7:0], slot1 = [15:8], 0x00 = empty.
- Diffs successive keycode words and emits serialized press/release (and optional typematic repeat) events through a FWFT FIFO with valid/ready handshake.
- Game logic pops events from this FIFO instead of polling raw keycodes.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥2.
- REPEAT_DELAY, 30, frame_tick count before first repeat event.
- REPEAT_RATE, 5, frame_tick count between subsequent repeat events.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- keycode  in  16  keycode word from PIO out_port.
- frame_tick  in  1  one-cycle pulse per video frame (repeat timebase).
- evt_data  out  10  {repeat, pressed, code[7:0]}; valid only while evt_valid=1.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer pop; pop occurs when evt_valid && evt_ready.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: an event was dropped.
- ovf_clr  in  1  clears overflow; set has priority on the same cycle.

Behaviour:
- Reset values: kc_q, prev, and snap all 0x0000; FSM in IDLE; FIFO empty; evt_valid=0; fifo_count=0; overflow=0; repeat counter=0.
- Input register: kc_q <= keycode every cycle.
- Normalisation: a slot1 code equal to a nonzero slot0 code is treated as 0x00, in both kc_q and prev.
- FSM states: IDLE, REL0, REL1, PRS0, PRS1. Each non-IDLE state lasts exactly 1 cycle.
  - IDLE: if normalised kc_q != prev, then snap <= kc_q and go to REL0. Else, if rpt_pending, push the repeat event, clear rpt_pending, stay in IDLE.
  - REL0 / REL1: if prev slot0 / slot1 is nonzero and absent from both snap slots, push {0,0,code}.
  - PRS0 / PRS1: if snap slot0 / slot1 is nonzero and absent from both prev slots, push {0,1,code}.
  - Exit PRS1: prev <= snap, go to IDLE.
- Event order within one scan: release slot0, release slot1, press slot0, press slot1.
- A keycode change during a scan is ignored until the FSM returns to IDLE. It is then detected against the updated prev. No change is lost, and intermediate glitches shorter than one scan may be merged.
- Slot swap only (same codes, different positions): no events.
- Latency: keycode changes at cycle 0; kc_q updates at cycle 1; REL0 runs at cycle 2; the first event is visible on evt_valid at cycle 3 (FIFO empty).
- FIFO (first-word fall-through):
  - evt_data always shows the head entry.
  - Push with count < DEPTH, or push with a same-cycle pop: accepted.
  - Push when full with no pop: event dropped, overflow <= 1.
  - Simultaneous push and pop: count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- Reset asserted mid-scan: FSM returns to IDLE, FIFO emptied, prev = 0. After reset, a held key produces a fresh press event.

Optional Feature:
- Macro: KEYCODE_REPEAT_EN.
- Defined (repeat enabled):
  - Repeat counter counts frame_tick while prev slot0 != 0.
  - Counter clears whenever prev slot0 changes, including to 0.
  - On reaching REPEAT_DELAY: set rpt_pending, reload counter so the next repeat occurs REPEAT_RATE ticks later.
  - Each later REPEAT_RATE ticks: set rpt_pending again.
  - Repeat event = {1,1,prev slot0}.
  - rpt_pending is a single bit; multiple expiries before service merge into one event.
  - Change detection in IDLE has priority over a pending repeat.
- Undefined (repeat disabled): no counter or rpt_pending logic; evt_data[9] is tied to 0; REPEAT_* parameters are unused.

Test Plan:
- Press: after reset, keycode 0x0000→0x001A, evt_ready=0 → evt_valid rises 3 cycles later, evt_data=0x11A, fifo_count=1.
- Mixed change: keycode 0x001A→0x0704, evt_ready=1 → events, in order, 0x01A, 0x104, 0x107; then evt_valid=0.
- Slot swap and duplicate: 0x0407→0x0704 gives no events; 0x0000→0x0505 gives a single event 0x105.
- Overflow: DEPTH=8, evt_ready=0, generate 9 events → fifo_count=8, overflow=1, head intact. Then pulse ovf_clr → overflow=0. Then pop 8 → events in original order.
- Repeat (macro defined): hold 0x0016 with frame_tick every 10 cycles → 0x116 on press; 0x316 after the 30th tick; then 0x316 every 5 ticks. Release → 0x016, and no further repeats.
- Reset mid-scan: assert reset while in PRS0 with 2 events queued → fifo_count=0, evt_valid=0. Held keycode 0x0004 → 0x104 re-emitted after reset deasserts.
